// File: rtl/minhash_matcher_if.sv
// MinHash matcher bus: signature/reference inputs and match/best results.
// master = signature generator side, slave = matcher side.
interface minhash_matcher_if #(
    parameter int S  = 4,
    parameter int CW = $clog2(S + 1)
);
    // generator -> matcher
    logic            load_ref;
    logic            sig_valid;
    logic [S*32-1:0] sig_in;
    logic [31:0]     w_idx;
    logic            clear_best;

    // matcher -> generator
    logic            sig_ready;
    logic            busy;
    logic            match_valid;
    logic [CW-1:0]   match_count;
    logic [31:0]     match_widx;
    logic            is_match;
    logic [CW-1:0]   best_count;
    logic [31:0]     best_widx;
    logic [15:0]     drop_cnt;

    modport master (
        output load_ref, sig_valid, sig_in, w_idx, clear_best,
        input  sig_ready, busy, match_valid, match_count,
        input  match_widx, is_match, best_count, best_widx,
        input  drop_cnt
    );

    modport slave (
        input  load_ref, sig_valid, sig_in, w_idx, clear_best,
        output sig_ready, busy, match_valid, match_count,
        output match_widx, is_match, best_count, best_widx,
        output drop_cnt
    );
endinterface

// File: rtl/minhash_matcher.sv
// MinHash signature matcher: compares each accepted signature against a
// stored reference one 32-bit lane per cycle and tracks the best window.
// Ports: clk, reset (async, active-high), bus (minhash_matcher_if.slave).
//   in : load_ref, sig_valid, sig_in[S*32], w_idx[32], clear_best
//   out: sig_ready, busy, match_valid, match_count, match_widx, is_match,
//        best_count, best_widx, drop_cnt[16]
module minhash_matcher #(
    parameter int S      = 4,
    parameter int THRESH = 2,
    parameter int CW     = $clog2(S + 1)
) (
    input  logic             clk,
    input  logic             reset,
    minhash_matcher_if.slave bus
);
    localparam int LW = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        REPORT
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic            ref_loaded;
    logic [S*32-1:0] ref_sig;
    logic [S*32-1:0] sig_lat;
    logic [31:0]     widx_lat;
    logic [LW-1:0]   lane;
    logic [CW-1:0]   cnt;

    logic            mv_q;
    logic [CW-1:0]   mcount_q;
    logic [31:0]     mwidx_q;
    logic            ismatch_q;
    logic [CW-1:0]   bcount_q;
    logic [31:0]     bwidx_q;
    logic [15:0]     drop_q;

    logic            sig_ready;
    logic            accept;
    logic            drop;
    logic            last_lane;
    logic            in_idle;
    logic            in_cmp;
    logic            in_rep;
    logic [31:0]     lat_lane;
    logic [31:0]     ref_lane;

    assign in_idle   = (state_q == IDLE);
    assign in_cmp    = (state_q == COMPARE);
    assign in_rep    = (state_q == REPORT);
    assign sig_ready = in_idle && ref_loaded;

    // load_ref wins a same-cycle collision; the signature is then dropped
    assign accept    = bus.sig_valid && sig_ready && !bus.load_ref;
    assign drop      = bus.sig_valid && !accept;
    assign last_lane = (lane == LW'(S - 1));

    always_comb begin
        lat_lane = '0;
        ref_lane = '0;
        for (int i = 0; i < S; i++) begin
            if (lane == LW'(i)) begin
                lat_lane = sig_lat[i*32 +: 32];
                ref_lane = ref_sig[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (last_lane) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ref_loaded <= 1'b0;
            ref_sig    <= '0;
            sig_lat    <= '0;
            widx_lat   <= '0;
            lane       <= '0;
            cnt        <= '0;
        end else begin
            if (in_idle && bus.load_ref) begin
                ref_sig    <= bus.sig_in;
                ref_loaded <= 1'b1;
            end
            if (accept) begin
                sig_lat  <= bus.sig_in;
                widx_lat <= bus.w_idx;
                lane     <= '0;
                cnt      <= '0;
            end
            if (in_cmp) begin
                // count tops out at S, which CW always holds
                if (lat_lane == ref_lane) begin
                    cnt <= cnt + CW'(1);
                end
                if (!last_lane) begin
                    lane <= lane + LW'(1);
                end
            end
        end
    end

    // Result registers load on the REPORT edge, so match_valid rises
    // one cycle after the last lane and the FSM is already back in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mv_q      <= 1'b0;
            mcount_q  <= '0;
            mwidx_q   <= '0;
            ismatch_q <= 1'b0;
        end else begin
            mv_q <= in_rep;
            if (in_rep) begin
                mcount_q  <= cnt;
                mwidx_q   <= widx_lat;
                ismatch_q <= (int'(cnt) >= THRESH);
            end
        end
    end

    // clear_best during REPORT clears first, then compares against zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcount_q <= '0;
            bwidx_q  <= '0;
        end else if (bus.clear_best) begin
            if (in_rep && (cnt != '0)) begin
                bcount_q <= cnt;
                bwidx_q  <= widx_lat;
            end else begin
                bcount_q <= '0;
                bwidx_q  <= '0;
            end
        end else if (in_rep && (cnt > bcount_q)) begin
            bcount_q <= cnt;
            bwidx_q  <= widx_lat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_q <= '0;
        end else if (drop && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 16'd1;
        end
    end

    assign bus.sig_ready   = sig_ready;
    assign bus.busy        = in_cmp || in_rep;
    assign bus.match_valid = mv_q;
    assign bus.match_count = mcount_q;
    assign bus.match_widx  = mwidx_q;
    assign bus.is_match    = ismatch_q;
    assign bus.best_count  = bcount_q;
    assign bus.best_widx   = bwidx_q;
    assign bus.drop_cnt    = drop_q;
endmodule

// File: tb/tb_minhash_matcher.sv
// Directed self-checking bench for minhash_matcher (S=4, THRESH=2).
// Drives the bus interface and checks results against hand-computed values.
module tb_minhash_matcher;
    localparam int S  = 4;
    localparam int CW = $clog2(S + 1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    minhash_matcher_if #(.S(S), .CW(CW)) bus ();

    minhash_matcher #(.S(S), .THRESH(2), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errs   = 0;
    int checks = 0;

    logic [S*32-1:0] r1;
    logic [S*32-1:0] r2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic load(input logic [S*32-1:0] r);
        bus.load_ref = 1'b1;
        bus.sig_in   = r;
        tick();
        bus.load_ref = 1'b0;
    endtask

    task automatic wait_mv(output int lat);
        lat = -1;
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            tick();
            if (bus.match_valid) lat = k;
        end
    endtask

    task automatic send(input logic [S*32-1:0] s,
                        input logic [31:0] w,
                        output int lat);
        bus.sig_valid = 1'b1;
        bus.sig_in    = s;
        bus.w_idx     = w;
        tick();
        bus.sig_valid = 1'b0;
        wait_mv(lat);
    endtask

    task automatic count_mv(input int n, output int seen);
        seen = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (bus.match_valid) seen++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.match_valid !== 1'b0) begin
            errs++;
            $display("FAIL rst_mv got %0b want 0", bus.match_valid);
        end
        checks++;
        if (bus.sig_ready !== 1'b0 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL rst_rdy_busy got %0b%0b want 00",
                     bus.sig_ready, bus.busy);
        end
        checks++;
        if (bus.best_count !== '0 || bus.drop_cnt !== 16'd0) begin
            errs++;
            $display("FAIL rst_best_drop got %0d/%0d want 0/0",
                     bus.best_count, bus.drop_cnt);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_exact();
        int lat;
        load(r1);
        send(r1, 32'd7, lat);
        checks++;
        if (lat !== S + 1) begin
            errs++;
            $display("FAIL exact_lat got %0d want %0d", lat, S + 1);
        end
        checks++;
        if (bus.match_count !== CW'(4) || bus.is_match !== 1'b1) begin
            errs++;
            $display("FAIL exact_cnt got %0d/%0b want 4/1",
                     bus.match_count, bus.is_match);
        end
        checks++;
        if (bus.match_widx !== 32'd7) begin
            errs++;
            $display("FAIL exact_widx got %0d want 7", bus.match_widx);
        end
        checks++;
        if (bus.best_count !== CW'(4) || bus.best_widx !== 32'd7) begin
            errs++;
            $display("FAIL exact_best got %0d/%0d want 4/7",
                     bus.best_count, bus.best_widx);
        end
        tick();
        checks++;
        if (bus.match_valid !== 1'b0) begin
            errs++;
            $display("FAIL exact_pulse got %0b want 0", bus.match_valid);
        end
    endtask

    task automatic test_partial();
        int lat;
        bus.clear_best = 1'b1;
        tick();
        bus.clear_best = 1'b0;
        checks++;
        if (bus.best_count !== '0 || bus.best_widx !== 32'd0) begin
            errs++;
            $display("FAIL clr_best got %0d/%0d want 0/0",
                     bus.best_count, bus.best_widx);
        end
        load(r2);
        send({32'hA, 32'h0, 32'hC, 32'h0}, 32'd2, lat);
        checks++;
        if (lat !== S + 1 || bus.match_count !== CW'(2) ||
            bus.is_match !== 1'b1) begin
            errs++;
            $display("FAIL part1 got lat%0d c%0d m%0b want lat5 c2 m1",
                     lat, bus.match_count, bus.is_match);
        end
        send({32'h0, 32'h0, 32'h0, 32'hD}, 32'd3, lat);
        checks++;
        if (lat !== S + 1 || bus.match_count !== CW'(1) ||
            bus.is_match !== 1'b0) begin
            errs++;
            $display("FAIL part2 got lat%0d c%0d m%0b want lat5 c1 m0",
                     lat, bus.match_count, bus.is_match);
        end
        checks++;
        if (bus.best_count !== CW'(2) || bus.best_widx !== 32'd2) begin
            errs++;
            $display("FAIL part_best got %0d/%0d want 2/2",
                     bus.best_count, bus.best_widx);
        end
        tick();
        tick();
        checks++;
        if (bus.match_count !== CW'(1) || bus.match_widx !== 32'd3) begin
            errs++;
            $display("FAIL part_hold got %0d/%0d want 1/3",
                     bus.match_count, bus.match_widx);
        end
    endtask

    task automatic test_drop();
        int seen;
        int lat;
        do_reset();
        bus.sig_valid = 1'b1;
        bus.sig_in    = r1;
        bus.w_idx     = 32'd1;
        tick();
        tick();
        bus.sig_valid = 1'b0;
        count_mv(10, seen);
        checks++;
        if (bus.drop_cnt !== 16'd2 || seen !== 0) begin
            errs++;
            $display("FAIL drop_noref got d%0d mv%0d want d2 mv0",
                     bus.drop_cnt, seen);
        end
        bus.load_ref  = 1'b1;
        bus.sig_valid = 1'b1;
        bus.sig_in    = r1;
        tick();
        bus.load_ref  = 1'b0;
        bus.sig_valid = 1'b0;
        checks++;
        if (bus.drop_cnt !== 16'd3 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL drop_prio got d%0d b%0b want d3 b0",
                     bus.drop_cnt, bus.busy);
        end
        bus.sig_valid = 1'b1;
        bus.sig_in    = r1;
        bus.w_idx     = 32'd20;
        tick();
        bus.sig_in    = '0;
        bus.w_idx     = 32'd21;
        tick();
        bus.sig_valid = 1'b0;
        bus.load_ref  = 1'b1;
        bus.sig_in    = r2;
        tick();
        bus.load_ref  = 1'b0;
        wait_mv(lat);
        checks++;
        if (lat < 0 || bus.drop_cnt !== 16'd4) begin
            errs++;
            $display("FAIL drop_busy got lat%0d d%0d want mv d4",
                     lat, bus.drop_cnt);
        end
        checks++;
        if (bus.match_widx !== 32'd20 || bus.match_count !== CW'(4)) begin
            errs++;
            $display("FAIL busy_keep got w%0d c%0d want w20 c4",
                     bus.match_widx, bus.match_count);
        end
        send(r1, 32'd22, lat);
        checks++;
        if (bus.match_count !== CW'(4) || bus.match_widx !== 32'd22) begin
            errs++;
            $display("FAIL ref_kept got c%0d w%0d want c4 w22",
                     bus.match_count, bus.match_widx);
        end
    endtask

    task automatic test_ties();
        int lat;
        do_reset();
        load(r1);
        send({32'd4, 32'd3, 32'd2, 32'd9}, 32'd5, lat);
        send({32'd4, 32'd3, 32'd2, 32'd9}, 32'd9, lat);
        checks++;
        if (bus.match_count !== CW'(3) || bus.best_count !== CW'(3) ||
            bus.best_widx !== 32'd5) begin
            errs++;
            $display("FAIL tie got c%0d b%0d/%0d want c3 b3/5",
                     bus.match_count, bus.best_count, bus.best_widx);
        end
        bus.sig_valid = 1'b1;
        bus.sig_in    = {32'd4, 32'd0, 32'd0, 32'd0};
        bus.w_idx     = 32'd11;
        tick();
        bus.sig_valid = 1'b0;
        repeat (S) tick();
        bus.clear_best = 1'b1;
        tick();
        bus.clear_best = 1'b0;
        checks++;
        if (bus.match_valid !== 1'b1 || bus.best_count !== CW'(1) ||
            bus.best_widx !== 32'd11) begin
            errs++;
            $display("FAIL clr_rep got mv%0b b%0d/%0d want mv1 b1/11",
                     bus.match_valid, bus.best_count, bus.best_widx);
        end
        bus.sig_valid = 1'b1;
        bus.sig_in    = '0;
        bus.w_idx     = 32'd12;
        tick();
        bus.sig_valid = 1'b0;
        repeat (S) tick();
        bus.clear_best = 1'b1;
        tick();
        bus.clear_best = 1'b0;
        checks++;
        if (bus.match_count !== '0 || bus.best_count !== '0 ||
            bus.best_widx !== 32'd0) begin
            errs++;
            $display("FAIL clr_zero got c%0d b%0d/%0d want c0 b0/0",
                     bus.match_count, bus.best_count, bus.best_widx);
        end
    endtask

    task automatic test_back_to_back();
        int lat1;
        int lat2;
        send(r1, 32'd30, lat1);
        send(r1, 32'd31, lat2);
        checks++;
        if (lat1 !== S + 1 || lat2 !== S + 1) begin
            errs++;
            $display("FAIL b2b_lat got %0d/%0d want 5/5", lat1, lat2);
        end
        checks++;
        if (bus.match_widx !== 32'd31 || bus.drop_cnt !== 16'd0) begin
            errs++;
            $display("FAIL b2b_data got w%0d d%0d want w31 d0",
                     bus.match_widx, bus.drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int lat;
        bus.sig_valid = 1'b1;
        bus.sig_in    = r1;
        bus.w_idx     = 32'd40;
        tick();
        bus.sig_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.sig_ready !== 1'b0 ||
            bus.match_valid !== 1'b0) begin
            errs++;
            $display("FAIL mid_ctl got b%0b r%0b mv%0b want 000",
                     bus.busy, bus.sig_ready, bus.match_valid);
        end
        checks++;
        if (bus.match_count !== '0 || bus.match_widx !== 32'd0 ||
            bus.best_count !== '0 || bus.best_widx !== 32'd0) begin
            errs++;
            $display("FAIL mid_data got c%0d w%0d b%0d/%0d want 0",
                     bus.match_count, bus.match_widx,
                     bus.best_count, bus.best_widx);
        end
        tick();
        reset = 1'b0;
        count_mv(8, seen);
        checks++;
        if (seen !== 0) begin
            errs++;
            $display("FAIL mid_nomv got %0d want 0", seen);
        end
        bus.sig_valid = 1'b1;
        bus.sig_in    = r1;
        tick();
        bus.sig_valid = 1'b0;
        checks++;
        if (bus.drop_cnt !== 16'd1 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL mid_drop got d%0d b%0b want d1 b0",
                     bus.drop_cnt, bus.busy);
        end
        load(r1);
        send(r1, 32'd41, lat);
        checks++;
        if (lat !== S + 1 || bus.match_count !== CW'(4)) begin
            errs++;
            $display("FAIL mid_reload got lat%0d c%0d want lat5 c4",
                     lat, bus.match_count);
        end
    endtask

    initial begin
        r1             = {32'd4, 32'd3, 32'd2, 32'd1};
        r2             = {32'hA, 32'hB, 32'hC, 32'hD};
        reset          = 1'b1;
        bus.load_ref   = 1'b0;
        bus.sig_valid  = 1'b0;
        bus.sig_in     = '0;
        bus.w_idx      = '0;
        bus.clear_best = 1'b0;
        test_reset();
        test_exact();
        test_partial();
        test_drop();
        test_ties();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
